// File: rtl/n64_pkg.sv
// Shared codes for the N64 button event generator: event kinds, stick zones,
// button indices and the scanner state encoding.
package n64_pkg;

  localparam logic [1:0] KIND_REL   = 2'b00;
  localparam logic [1:0] KIND_PRESS = 2'b01;
  localparam logic [1:0] KIND_STX   = 2'b10;
  localparam logic [1:0] KIND_STY   = 2'b11;

  typedef enum logic [1:0] {
    ZONE_CENTER = 2'b00,
    ZONE_POS    = 2'b01,
    ZONE_NEG    = 2'b10
  } zone_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SCAN   = 2'b01,
    ST_COMMIT = 2'b10
  } state_t;

  localparam int BTN_A     = 0;
  localparam int BTN_B     = 1;
  localparam int BTN_Z     = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP    = 4;
  localparam int BTN_DOWN  = 5;
  localparam int BTN_LEFT  = 6;
  localparam int BTN_RIGHT = 7;
  localparam int IDX_RSVD0 = 8;
  localparam int IDX_RSVD1 = 9;
  localparam int BTN_L     = 10;
  localparam int BTN_R     = 11;
  localparam int BTN_CU    = 12;
  localparam int BTN_CD    = 13;
  localparam int BTN_CL    = 14;
  localparam int BTN_CR    = 15;

  // Button field as stored (bit 15 = A ... bit 0 = CR); reserved bits 7:6 masked off.
  localparam logic [15:0] BTN_MASK = 16'hFF3F;

  localparam int SCAN_LAST = 17;

  // Widened to 9 bits so that -128 against -DEADZONE compares correctly.
  function automatic zone_t zone_of(input logic [7:0] raw, input int deadzone);
    logic signed [8:0] v;
    logic signed [8:0] th;
    v  = signed'({raw[7], raw});
    th = signed'(9'(deadzone));
    if (v > th)
      return ZONE_POS;
    else if (v < -th)
      return ZONE_NEG;
    else
      return ZONE_CENTER;
  endfunction

endpackage

// File: rtl/n64_button_event_gen_if.sv
// Snapshot input, event stream handshake and status flags of the event generator.
interface n64_button_event_gen_if;

  logic [31:0] button_data;
  logic [7:0]  ev_data;
  logic        ev_valid;
  logic        ev_ready;
  logic        busy;
  logic        overflow;
  logic        clr_overflow;

  modport master (
    input  button_data, ev_ready, clr_overflow,
    output ev_data, ev_valid, busy, overflow
  );

  modport slave (
    output button_data, ev_ready, clr_overflow,
    input  ev_data, ev_valid, busy, overflow
  );

endinterface

// File: rtl/n64_event_fifo.sv
// Show-ahead synchronous FIFO; a push onto a full FIFO is accepted only when a
// pop happens in the same cycle.
module n64_event_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/n64_button_event_gen.sv
// Compares successive controller snapshots against a committed shadow and
// queues one event per changed button or stick zone, in index order.
module n64_button_event_gen
  import n64_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int DEADZONE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  n64_button_event_gen_if.master bus
);

  logic [31:0] in_reg;
  logic [15:0] in_btn;
  zone_t       in_zx;
  zone_t       in_zy;

  logic [15:0] shadow_btn;
  zone_t       shadow_zx;
  zone_t       shadow_zy;
  logic [15:0] snap_btn;
  zone_t       snap_zx;
  zone_t       snap_zy;

  state_t      state;
  state_t      state_next;
  logic [4:0]  idx;
  logic [3:0]  btn_pos;
  logic        changed;
  logic        latch;
  logic        commit;
  logic        push;
  logic [7:0]  push_data;

  logic        fifo_full;
  logic        fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic        pop_accept;
  logic        drop;
  logic        overflow_q;

  assign in_btn  = in_reg[31:16] & BTN_MASK;
  assign in_zx   = zone_of(in_reg[15:8], DEADZONE);
  assign in_zy   = zone_of(in_reg[7:0], DEADZONE);
  assign changed = ((in_btn ^ shadow_btn) != 16'h0000) ||
                   (in_zx != shadow_zx) || (in_zy != shadow_zy);
  assign btn_pos = 4'd15 - idx[3:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      in_reg <= '0;
    else
      in_reg <= bus.button_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    latch      = 1'b0;
    commit     = 1'b0;
    push       = 1'b0;
    push_data  = 8'h00;
    case (state)
      ST_IDLE: begin
        if (changed) begin
          latch      = 1'b1;
          state_next = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (idx < 5'd16) begin
          if ((idx != 5'(IDX_RSVD0)) && (idx != 5'(IDX_RSVD1)) &&
              (snap_btn[btn_pos] != shadow_btn[btn_pos])) begin
            push      = 1'b1;
            push_data = {snap_btn[btn_pos] ? KIND_PRESS : KIND_REL, 2'b00, idx[3:0]};
          end
        end else if (idx == 5'd16) begin
          if (snap_zx != shadow_zx) begin
            push      = 1'b1;
            push_data = {KIND_STX, 4'b0000, snap_zx};
          end
        end else begin
          if (snap_zy != shadow_zy) begin
            push      = 1'b1;
            push_data = {KIND_STY, 4'b0000, snap_zy};
          end
        end
        if (idx == 5'(SCAN_LAST))
          state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Zones are quantised once at latch time so the scan and commit see one view.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      snap_btn   <= '0;
      snap_zx    <= ZONE_CENTER;
      snap_zy    <= ZONE_CENTER;
      shadow_btn <= '0;
      shadow_zx  <= ZONE_CENTER;
      shadow_zy  <= ZONE_CENTER;
    end else begin
      if (latch) begin
        idx      <= '0;
        snap_btn <= in_btn;
        snap_zx  <= in_zx;
        snap_zy  <= in_zy;
      end else if (state == ST_SCAN) begin
        idx <= idx + 1'b1;
      end
      if (commit) begin
        shadow_btn <= snap_btn;
        shadow_zx  <= snap_zx;
        shadow_zy  <= snap_zy;
      end
    end
  end

  n64_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.ev_ready),
    .pop_data  (bus.ev_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign pop_accept = bus.ev_ready && (fifo_count != '0);
  assign drop       = push && fifo_full && !pop_accept;

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overflow_q <= 1'b0;
    else if (drop)
      overflow_q <= 1'b1;
    else if (bus.clr_overflow)
      overflow_q <= 1'b0;
  end

  assign bus.ev_valid = !fifo_empty;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.overflow = overflow_q;

endmodule
